// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan driver.
// Digit codes and active-low {a..g} segment patterns.
package ssd_pkg;

    localparam logic [4:0] SSD_BLANK = 5'd16;
    localparam logic [4:0] SSD_DASH  = 5'd17;

    localparam logic [6:0] SEG_0    = 7'b0000001;
    localparam logic [6:0] SEG_1    = 7'b1001111;
    localparam logic [6:0] SEG_2    = 7'b0010010;
    localparam logic [6:0] SEG_3    = 7'b0000110;
    localparam logic [6:0] SEG_4    = 7'b1001100;
    localparam logic [6:0] SEG_5    = 7'b0100100;
    localparam logic [6:0] SEG_6    = 7'b0100000;
    localparam logic [6:0] SEG_7    = 7'b0001111;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0000100;
    localparam logic [6:0] SEG_A    = 7'b0001000;
    localparam logic [6:0] SEG_B    = 7'b1100000;
    localparam logic [6:0] SEG_C    = 7'b0110001;
    localparam logic [6:0] SEG_D    = 7'b1000010;
    localparam logic [6:0] SEG_E    = 7'b0110000;
    localparam logic [6:0] SEG_F    = 7'b0111000;
    localparam logic [6:0] SEG_DASH = 7'b1111110;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/ssd_seg_decode.sv
// Combinational digit-code to active-low segment decoder.
// Codes 0-15 are hex glyphs, 17 is a dash, all others blank.
module ssd_seg_decode
    import ssd_pkg::*;
(
    input  logic [4:0] code_i,
    output logic [6:0] seg_o
);

    // Map the 5-bit code onto its glyph
    always_comb begin
        seg_o = SEG_OFF;
        case (code_i)
            5'd0:     seg_o = SEG_0;
            5'd1:     seg_o = SEG_1;
            5'd2:     seg_o = SEG_2;
            5'd3:     seg_o = SEG_3;
            5'd4:     seg_o = SEG_4;
            5'd5:     seg_o = SEG_5;
            5'd6:     seg_o = SEG_6;
            5'd7:     seg_o = SEG_7;
            5'd8:     seg_o = SEG_8;
            5'd9:     seg_o = SEG_9;
            5'd10:    seg_o = SEG_A;
            5'd11:    seg_o = SEG_B;
            5'd12:    seg_o = SEG_C;
            5'd13:    seg_o = SEG_D;
            5'd14:    seg_o = SEG_E;
            5'd15:    seg_o = SEG_F;
            SSD_DASH: seg_o = SEG_DASH;
            default:  seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver with PWM dimming,
// guard interval, blinking and double-buffered display data.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int N_DIGITS  = 8,
    parameter int SCAN_DIV  = 18,
    parameter int BRIGHT_W  = 4,
    parameter int GUARD_CYC = 64,
    parameter int BLINK_DIV = 26
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Load,
    input  logic [5*N_DIGITS-1:0] DigitData,
    input  logic [N_DIGITS-1:0]   DpIn,
    input  logic [N_DIGITS-1:0]   BlinkMask,
    input  logic [BRIGHT_W-1:0]   Brightness,
    output logic [N_DIGITS-1:0]   An,
    output logic [7:0]            Cathodes,
    output logic                  FrameDone
);

    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [SCAN_DIV-1:0] GUARD = SCAN_DIV'(GUARD_CYC);
    localparam logic [DW-1:0] LAST = DW'(N_DIGITS - 1);

    logic [SCAN_DIV-1:0]   slot_q, slot_d;
    logic [DW-1:0]         dig_q, dig_d;
    logic [BLINK_DIV-1:0]  blink_q, blink_d;

    logic [5*N_DIGITS-1:0] sh_code_q, act_code_q;
    logic [N_DIGITS-1:0]   sh_dp_q, act_dp_q;
    logic [N_DIGITS-1:0]   sh_mask_q, act_mask_q;
    logic [BRIGHT_W-1:0]   act_bright_q;

    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [7:0]            cath_q, cath_d;
    logic                  fd_q, fd_d;

    logic                  slot_wrap;
    logic                  slot_start;
    logic [4:0]            code_sel;
    logic                  dp_sel;
    logic                  mask_sel;
    logic [BRIGHT_W-1:0]   phase;
    logic                  blink_off;
    logic                  dig_on;
    logic [6:0]            seg;

    assign slot_wrap  = &slot_q;
    assign slot_start = (slot_q == '0);
    assign phase      = slot_q[SCAN_DIV-1 -: BRIGHT_W];
    assign blink_off  = blink_q[BLINK_DIV-1];

    // Next-state of the slot, digit and blink counters
    always_comb begin
        slot_d  = slot_q + 1'b1;
        blink_d = blink_q + 1'b1;
        dig_d   = dig_q;
        if (slot_wrap) begin
            dig_d = (dig_q == LAST) ? '0 : dig_q + 1'b1;
        end
    end

    // Pick the active data belonging to the digit being scanned
    always_comb begin
        code_sel = SSD_BLANK;
        dp_sel   = 1'b0;
        mask_sel = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (dig_q == DW'(i)) begin
                code_sel = act_code_q[5*i +: 5];
                dp_sel   = act_dp_q[i];
                mask_sel = act_mask_q[i];
            end
        end
    end

    ssd_seg_decode u_dec (
        .code_i (code_sel),
        .seg_o  (seg)
    );

    // Guard, PWM and blink gating feed the next output values
    always_comb begin
        dig_on = (slot_q >= GUARD)
              && (phase < act_bright_q)
              && !(mask_sel && blink_off);
        for (int i = 0; i < N_DIGITS; i++) begin
            an_d[i] = !(dig_on && (dig_q == DW'(i)));
        end
        cath_d = dig_on ? {seg, ~dp_sel} : 8'hFF;
        fd_d   = slot_wrap && (dig_q == LAST);
    end

    // Free-running scan and blink counters
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            slot_q  <= '0;
            dig_q   <= '0;
            blink_q <= '0;
        end else begin
            slot_q  <= slot_d;
            dig_q   <= dig_d;
            blink_q <= blink_d;
        end
    end

    // Shadow registers take host data on each Load strobe
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sh_code_q <= {N_DIGITS{SSD_BLANK}};
            sh_dp_q   <= '0;
            sh_mask_q <= '0;
        end else if (Load) begin
            sh_code_q <= DigitData;
            sh_dp_q   <= DpIn;
            sh_mask_q <= BlinkMask;
        end
    end

    // Active registers refresh only at slot start so a digit never tears
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            act_code_q   <= {N_DIGITS{SSD_BLANK}};
            act_dp_q     <= '0;
            act_mask_q   <= '0;
            act_bright_q <= '0;
        end else if (slot_start) begin
            act_code_q   <= sh_code_q;
            act_dp_q     <= sh_dp_q;
            act_mask_q   <= sh_mask_q;
            act_bright_q <= Brightness;
        end
    end

    // Registered anode, cathode and frame outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            an_q   <= '1;
            cath_q <= 8'hFF;
            fd_q   <= 1'b0;
        end else begin
            an_q   <= an_d;
            cath_q <= cath_d;
            fd_q   <= fd_d;
        end
    end

    assign An        = an_q;
    assign Cathodes  = cath_q;
    assign FrameDone = fd_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed self-checking bench for ssd_scan_driver.
// Frame cycle c = digit c/64, slot cycle c%64 (4 digits x 64 clocks).
module tb_ssd_scan_driver;

    logic        Clk;
    logic        Reset;
    logic        Load;
    logic [19:0] DigitData;
    logic [3:0]  DpIn;
    logic [3:0]  BlinkMask;
    logic [1:0]  Brightness;
    logic [3:0]  An;
    logic [7:0]  Cathodes;
    logic        FrameDone;

    int checks;
    int errors;
    int fc;
    int n;
    int bad;
    int pulses;

    ssd_scan_driver #(
        .N_DIGITS  (4),
        .SCAN_DIV  (6),
        .BRIGHT_W  (2),
        .GUARD_CYC (4),
        .BLINK_DIV (9)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Load       (Load),
        .DigitData  (DigitData),
        .DpIn       (DpIn),
        .BlinkMask  (BlinkMask),
        .Brightness (Brightness),
        .An         (An),
        .Cathodes   (Cathodes),
        .FrameDone  (FrameDone)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait for the next FrameDone (bounded); fc=0 at the frame start
    task automatic wait_frame(output int cnt);
        cnt = 0;
        do begin
            @(negedge Clk);
            cnt++;
        end while (!FrameDone && cnt < 1000);
        check("fd_seen", {31'd0, FrameDone}, 1);
        fc = 0;
    endtask

    // At return, outputs reflect frame cycle target-1
    task automatic adv(input int target);
        while (fc < target) begin
            @(negedge Clk);
            fc++;
        end
    endtask

    // Check outputs for frame cycle c
    task automatic at(input string tag, input int c,
                      input logic [3:0] an_e, input logic [7:0] ca_e);
        adv(c + 1);
        check({tag, "_an"}, {28'd0, An}, {28'd0, an_e});
        check({tag, "_cath"}, {24'd0, Cathodes}, {24'd0, ca_e});
    endtask

    task automatic load(input logic [19:0] d, input logic [3:0] dp,
                        input logic [3:0] m);
        DigitData = d;
        DpIn      = dp;
        BlinkMask = m;
        Load      = 1'b1;
        @(negedge Clk);
        fc++;
        Load = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; fc = 0;
        Reset = 1'b1; Load = 1'b0;
        DigitData = '0; DpIn = '0; BlinkMask = '0; Brightness = 2'd0;
        repeat (3) @(negedge Clk);
        check("rst_an", {28'd0, An}, 32'hF);
        check("rst_cath", {24'd0, Cathodes}, 32'hFF);
        check("rst_fd", {31'd0, FrameDone}, 0);
        Reset = 1'b0;

        // Idle after reset: dark, FrameDone every 256 clocks
        bad = 0; pulses = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge Clk);
            if (An !== 4'hF || Cathodes !== 8'hFF) bad++;
            if (FrameDone) pulses++;
        end
        check("idle_dark", bad, 0);
        check("idle_pulses", pulses, 2);
        wait_frame(n);
        check("idle_fd_first", n, 168);
        wait_frame(n);
        check("idle_fd_period", n, 256);

        // Codes {3,2,1,0}, full brightness; load hits slot 0 of digit 0
        Brightness = 2'd3;
        load({5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000, 4'b0000);
        at("d0_c4_oldblank", 4, 4'hE, 8'hFF);
        wait_frame(n);
        at("d0_c3", 3, 4'hF, 8'hFF);
        at("d0_c4", 4, 4'hE, 8'h03);
        at("d0_c47", 47, 4'hE, 8'h03);
        at("d0_c48", 48, 4'hF, 8'hFF);
        at("d0_c63", 63, 4'hF, 8'hFF);
        at("d1_c68", 68, 4'hD, 8'h9F);
        at("d2_c138", 138, 4'hB, 8'h25);
        at("d3_c212", 212, 4'h7, 8'h0D);

        // Mid-frame load at slot 30 of digit 2: no tearing
        wait_frame(n);
        adv(158);
        load({5'd13, 5'd12, 5'd11, 5'd10}, 4'b1000, 4'b0000);
        at("tear_d2_old", 170, 4'hB, 8'h25);
        at("tear_d3_new", 200, 4'h7, 8'h84);
        wait_frame(n);
        at("tear_d0_new", 10, 4'hE, 8'h11);
        at("tear_d2_new", 138, 4'hB, 8'h63);

        // Brightness 1: lit only on slot cycles 4-15
        Brightness = 2'd1;
        load({4{5'd8}}, 4'b0000, 4'b0000);
        wait_frame(n);
        at("b1_c3", 3, 4'hF, 8'hFF);
        at("b1_c4", 4, 4'hE, 8'h01);
        at("b1_c15", 15, 4'hE, 8'h01);
        at("b1_c16", 16, 4'hF, 8'hFF);
        at("b1_d3_c202", 202, 4'h7, 8'h01);
        Brightness = 2'd0;
        wait_frame(n);
        at("b0_c10", 10, 4'hF, 8'hFF);
        at("b0_c74", 74, 4'hF, 8'hFF);

        // Asynchronous reset while lit
        Brightness = 2'd3;
        wait_frame(n);
        at("pre_rst_c20", 20, 4'hE, 8'h01);
        Reset = 1'b1;
        #1;
        check("async_rst_an", {28'd0, An}, 32'hF);
        check("async_rst_cath", {24'd0, Cathodes}, 32'hFF);
        check("async_rst_fd", {31'd0, FrameDone}, 0);
        Brightness = 2'd0;
        @(negedge Clk);
        Reset = 1'b0;
        wait_frame(n);
        check("post_rst_fd", n, 256);

        // Blink on digit 1, all dashes; blink_off in odd frames
        Brightness = 2'd3;
        load({4{5'd17}}, 4'b0000, 4'b0010);
        at("blk_f1_d1", 74, 4'hF, 8'hFF);
        at("blk_f1_d2", 138, 4'hB, 8'hFD);
        wait_frame(n);
        at("blk_f2_d0", 10, 4'hE, 8'hFD);
        at("blk_f2_d1", 74, 4'hD, 8'hFD);
        at("blk_f2_d3", 202, 4'h7, 8'hFD);
        wait_frame(n);
        at("blk_f3_d1", 74, 4'hF, 8'hFF);
        at("blk_f3_d3", 202, 4'h7, 8'hFD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Parametrised multiplexed seven-segment display driver that replaces per-project hand-written anode and cathode scan logic in the board top level. It time-multiplexes N_DIGITS digit codes onto a shared active-low cathode bus. Per digit it supports decimal point, blanking, a dash glyph and blinking. Brightness comes from PWM dimming, and a ghost-suppression guard interval follows each digit switch. Display data is double-buffered so a mid-frame update never tears a digit.

## Interface
Parameters:
- N_DIGITS, 8, number of digits/anodes (2–16; non-power-of-two allowed)
- SCAN_DIV, 18, digit slot length = 2^SCAN_DIV clocks
- BRIGHT_W, 4, brightness field width; PWM phase = top BRIGHT_W bits of slot counter
- GUARD_CYC, 64, clocks at start of each slot with all anodes off (< 2^SCAN_DIV)
- BLINK_DIV, 26, blink half-period = 2^(BLINK_DIV-1) clocks

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- Load  in  1  single-cycle strobe; capture DigitData/DpIn/BlinkMask into shadow registers
- DigitData  in  5*N_DIGITS  digit i code at [5i+4:5i]; 0–15 hex, 16 blank, 17 dash, 18–31 blank
- DpIn  in  N_DIGITS  decimal point enable per digit
- BlinkMask  in  N_DIGITS  digit blinks when set
- Brightness  in  BRIGHT_W  PWM level; 0 = dark, 2^BRIGHT_W-1 = maximum
- An  out  N_DIGITS  anodes, active low
- Cathodes  out  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active low
- FrameDone  out  1  one-cycle pulse at end of last digit slot

## Operation
- Shadow registers: a Load in cycle t writes codes, dp and mask at edge t+1. Back-to-back Loads are allowed; the last one wins.
- Active registers: the shadow content and the Brightness input are copied into active registers on the first cycle of every digit slot (slot_cnt == 0). Display always reads the active registers.
- slot_cnt: SCAN_DIV-bit free-running counter.
- dig_idx: increments when slot_cnt wraps. It wraps from N_DIGITS-1 to 0.
- blink_cnt: BLINK_DIV-bit free-running counter. blink_off = blink_cnt MSB.
- Digit on-condition: slot_cnt >= GUARD_CYC, and phase < active brightness, and not (mask[dig_idx] and blink_off). phase = slot_cnt[SCAN_DIV-1 -: BRIGHT_W].
- An: the bit for dig_idx is 0 when the digit is on. All other bits are 1.
- Cathodes: the decoded segments of code[dig_idx], with Dp = ~dp[dig_idx].
  - When the digit is off, all Cathodes bits are 1.
  - A blank code drives all segments high. The Dp bit still follows dp[dig_idx].
- Segment patterns {a..g}, active low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - dash=1111110
- FrameDone: asserted for the single cycle after slot_cnt wraps while dig_idx was N_DIGITS-1. It is aligned with An.

## Timing
- Reset values: An all 1s, Cathodes 8'hFF, FrameDone 0. All counters are 0. Shadow and active codes = 16 (blank), dp = 0, mask = 0, active brightness = 0.
- Outputs are registered. An, Cathodes and FrameDone reflect counter state with 1-cycle latency.
- Load-to-display latency: the new data appears from the next slot start after the shadow write, at most 2^SCAN_DIV+2 clocks.
- If Load coincides with slot_cnt == 0, the old shadow is copied this slot and the new data is shown next slot.
- Brightness changes take effect only at slot start.
- Reset asserted mid-operation blanks the outputs immediately (asynchronously). The first slot after release is digit 0 and is dark, because active brightness = 0.

## Structure
- Shared package ssd_pkg holds:
  - code constants SSD_BLANK = 5'd16 and SSD_DASH = 5'd17
  - the 7-bit segment pattern constants
- Sub-module ssd_seg_decode: combinational 5-bit code to 7-bit active-low segments.
- The counters, shadow/active registers, PWM compare and output registers stay in ssd_scan_driver.

## Test plan
All scenarios use N_DIGITS=4, SCAN_DIV=6, BRIGHT_W=2, GUARD_CYC=4, BLINK_DIV=9.
- Reset, then no Load -> An=4'b1111, Cathodes=8'hFF for 600 clocks. FrameDone pulses every 256 clocks.
- Load codes {3,2,1,0}, Brightness=3 -> in the digit 0 slot, An=4'b1110 on slot cycles 4–47 and Cathodes=8'b00000011. It is dark on cycles 48–63 and 0–3.
- Brightness=1, digit code 8 -> An active on slot cycles 4–15 only. Brightness=0 -> An=4'b1111 throughout.
- BlinkMask=4'b0010, codes all 17 -> digit 1 shows 8'b11111101 for 256 clocks, then is dark for 256 clocks. Digits 0, 2 and 3 are unaffected.
- Load issued at slot_cnt=30 of digit 2 -> digit 2 keeps its old pattern until the slot ends. Digit 3 shows the new data in the next slot.
- Reset asserted at slot_cnt=20 while lit -> An=4'b1111 in the same cycle. After release, dig_idx=0 and slot_cnt=0.
